// File: rtl/aes_spi_cmd_slave.sv
// aes_spi_cmd_slave: command-based SPI mode-0 slave front-end for the AES
// cores. sclk/cs_n/mosi are oversampled in the clk domain.
module aes_spi_cmd_slave #(
  parameter int NK = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic             core_start,
  output logic             core_mode,
  output logic [127:0]     core_data,
  output logic [32*NK-1:0] core_key,
  input  logic             core_done,
  input  logic [127:0]     core_result,
  output logic             busy
);
  localparam int KW  = 32 * NK;
  localparam int TOT = 128 + KW;
  localparam int CW  = $clog2(TOT);
  localparam logic [CW-1:0] LOAD_LAST = CW'(TOT - 1);
  localparam logic [CW-1:0] RD_LAST   = CW'(135);
  localparam logic [CW-1:0] RD_END    = CW'(136);

  typedef enum logic [2:0] {
    IDLE, CMD, LOAD, START, READ, DRAIN
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, bit_in;
  logic                   rise, fall, cs_fall;
  logic [6:0]             cmd_sh;
  logic [7:0]             cmd;
  logic [CW-1:0]          cnt;
  logic [TOT-1:0]         sh;
  logic [127:0]           result;
  logic                   rv, err, pend_mode, got;
  logic [7:0]             status;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign bit_in  = mosi_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign cs_fall = ~cs_s & cs_d;
  assign cmd     = {cmd_sh, bit_in};
  assign status  = {busy, rv, err, core_mode, 4'b0};
  assign got     = core_done & busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      core_start <= 1'b0;
      core_mode  <= 1'b0;
      core_data  <= '0;
      core_key   <= '0;
      busy       <= 1'b0;
      cmd_sh     <= '0;
      cnt        <= '0;
      sh         <= '0;
      result     <= '0;
      rv         <= 1'b0;
      err        <= 1'b0;
      pend_mode  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      miso_oe    <= ~cs_s;
      if (got) begin
        result <= core_result;
        busy   <= 1'b0;
        rv     <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= CMD;
            cnt   <= '0;
          end else if (!cs_s && rise) begin
            state <= DRAIN;
          end
        end
        CMD: begin
          if (cs_s) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (rise) begin
            cmd_sh <= cmd[6:0];
            cnt    <= cnt + 1'b1;
            if (cnt[2:0] == 3'd7) begin
              cnt <= '0;
              unique case (1'b1)
                cmd == 8'h03: begin
                  state <= READ;
                  sh    <= {status, rv ? result : 128'b0,
                            {(TOT-136){1'b0}}};
                end
                (cmd == 8'h01 || cmd == 8'h02) && !busy: begin
                  state     <= LOAD;
                  pend_mode <= cmd[0];
                end
                default: begin
                  state <= DRAIN;
                  err   <= 1'b1;
                end
              endcase
            end
          end
        end
        LOAD: begin
          if (cs_s) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (rise) begin
            sh  <= {sh[TOT-2:0], bit_in};
            cnt <= cnt + 1'b1;
            if (cnt == LOAD_LAST) state <= START;
          end
        end
        START: begin
          core_data  <= sh[TOT-1:KW];
          core_key   <= sh[KW-1:0];
          core_mode  <= pend_mode;
          core_start <= 1'b1;
          busy       <= 1'b1;
          rv         <= 1'b0;
          state      <= IDLE;
        end
        READ: begin
          if (cs_s) begin
            state <= IDLE;
            miso  <= 1'b0;
          end else if (fall) begin
            miso <= sh[TOT-1];
            sh   <= {sh[TOT-2:0], 1'b0};
            if (cnt != RD_END) cnt <= cnt + 1'b1;
            // a result landing on the final fall must survive the clear
            if (cnt == RD_LAST) begin
              err <= 1'b0;
              if (!got) rv <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (cs_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_spi_cmd_slave.sv
// tb_aes_spi_cmd_slave: directed checks of the command SPI slave
// with NK=4 and NK=8 instances and a simple AES core stand-in.
`timescale 1ns/1ps
module tb_aes_spi_cmd_slave;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D2 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] K2 = 128'h55aa55aa0f0f0f0ff0f0f0f033cc33cc;
  localparam logic [127:0] D6 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] K6 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk, rst, sclk, mosi, cs_n4, cs_n8;
  logic miso4, miso_oe4, core_start4, core_mode4, busy4;
  logic [127:0] core_data4, core_result4;
  logic [127:0] core_key4;
  logic core_done4, kick4, core_done4_w;
  logic miso8, miso_oe8, core_start8, core_mode8, busy8;
  logic [127:0] core_data8, core_result8;
  logic [255:0] core_key8;
  logic core_done8;
  logic auto4, auto8, mon;
  int n_assert, n_fail;
  int n_start4, n_start8, miso_hi;

  assign core_done4_w = core_done4 | kick4;

  aes_spi_cmd_slave #(.NK(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n4), .mosi(mosi),
    .miso(miso4), .miso_oe(miso_oe4), .core_start(core_start4),
    .core_mode(core_mode4), .core_data(core_data4),
    .core_key(core_key4), .core_done(core_done4_w),
    .core_result(core_result4), .busy(busy4));

  aes_spi_cmd_slave #(.NK(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n8), .mosi(mosi),
    .miso(miso8), .miso_oe(miso_oe8), .core_start(core_start8),
    .core_mode(core_mode8), .core_data(core_data8),
    .core_key(core_key8), .core_done(core_done8),
    .core_result(core_result8), .busy(busy8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    n_start4 = 0;
    n_start8 = 0;
    miso_hi = 0;
  end

  always @(negedge clk) begin
    if (core_start4 === 1'b1) n_start4++;
    if (core_start8 === 1'b1) n_start8++;
    if (mon && miso4 !== 1'b0) miso_hi++;
  end

  // core stand-in: fixed answer for the known vector, else ~data
  initial begin
    core_done4 = 1'b0;
    core_result4 = '0;
    forever begin
      @(negedge clk);
      if (core_start4 === 1'b1 && auto4) begin
        repeat (3) @(negedge clk);
        core_result4 = (core_data4 == D1 && core_key4 == K1) ?
                       R1 : ~core_data4;
        core_done4 = 1'b1;
        @(negedge clk);
        core_done4 = 1'b0;
      end
    end
  end

  initial begin
    core_done8 = 1'b0;
    core_result8 = '0;
    forever begin
      @(negedge clk);
      if (core_start8 === 1'b1 && auto8) begin
        repeat (3) @(negedge clk);
        core_result8 = ~core_data8;
        core_done8 = 1'b1;
        @(negedge clk);
        core_done8 = 1'b0;
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    cs_n4 = 1'b1;
    cs_n8 = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    kick4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input bit s8, input int n, input logic [519:0] tx,
                       input int h, input int gap,
                       output logic [519:0] rx);
    rx = '0;
    if (s8) cs_n8 = 1'b0;
    else cs_n4 = 1'b0;
    #(h);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      #(h);
      sclk = 1'b1;
      rx = {rx[518:0], s8 ? miso8 : miso4};
      #(h);
      sclk = 1'b0;
    end
    #(h);
    cs_n4 = 1'b1;
    cs_n8 = 1'b1;
    mosi = 1'b0;
    #(gap);
  endtask

  task automatic do_read(input bit s8, input int gap,
                         output logic [7:0] st, output logic [127:0] res);
    logic [519:0] rx;
    frame(s8, 144, 520'({8'h03, 136'h0}), 40, gap, rx);
    st = rx[135:128];
    res = rx[127:0];
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if (miso4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_miso: got %b want 0", miso4);
    end
    n_assert++;
    if (miso_oe4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_miso_oe: got %b want 0", miso_oe4);
    end
    n_assert++;
    if (core_start4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_start: got %b want 0", core_start4);
    end
    n_assert++;
    if (core_mode4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mode: got %b want 0", core_mode4);
    end
    n_assert++;
    if (core_data4 !== 128'h0) begin
      n_fail++; $display("FAIL rst_data: got %h want 0", core_data4);
    end
    n_assert++;
    if (core_key4 !== 128'h0) begin
      n_fail++; $display("FAIL rst_key: got %h want 0", core_key4);
    end
    n_assert++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy: got %b want 0", busy4);
    end
  endtask

  task automatic test_encrypt();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    int s0;
    do_reset();
    auto4 = 1'b1;
    s0 = n_start4;
    frame(1'b0, 264, 520'({8'h01, D1, K1}), 20, 200, rx);
    n_assert++;
    if (n_start4 - s0 !== 1) begin
      n_fail++; $display("FAIL enc_starts: got %0d want 1", n_start4 - s0);
    end
    n_assert++;
    if (core_data4 !== D1) begin
      n_fail++; $display("FAIL enc_data: got %h want %h", core_data4, D1);
    end
    n_assert++;
    if (core_key4 !== K1) begin
      n_fail++; $display("FAIL enc_key: got %h want %h", core_key4, K1);
    end
    n_assert++;
    if (core_mode4 !== 1'b1) begin
      n_fail++; $display("FAIL enc_mode: got %b want 1", core_mode4);
    end
    n_assert++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL enc_busy: got %b want 0", busy4);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h50) begin
      n_fail++; $display("FAIL enc_status: got %h want 50", st);
    end
    n_assert++;
    if (res !== R1) begin
      n_fail++; $display("FAIL enc_result: got %h want %h", res, R1);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h10) begin
      n_fail++; $display("FAIL enc_status2: got %h want 10", st);
    end
    n_assert++;
    if (res !== 128'h0) begin
      n_fail++; $display("FAIL enc_result2: got %h want 0", res);
    end
  endtask

  task automatic test_abort();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    int s0;
    do_reset();
    auto4 = 1'b1;
    s0 = n_start4;
    frame(1'b0, 58, 520'({8'h01, D1[127:78]}), 20, 200, rx);
    n_assert++;
    if (n_start4 - s0 !== 0) begin
      n_fail++; $display("FAIL abort_starts: got %0d want 0", n_start4 - s0);
    end
    n_assert++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b want 0", busy4);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h20) begin
      n_fail++; $display("FAIL abort_status: got %h want 20", st);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h00) begin
      n_fail++; $display("FAIL abort_status2: got %h want 00", st);
    end
  endtask

  task automatic test_illegal();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    int s0, m0;
    do_reset();
    auto4 = 1'b1;
    s0 = n_start4;
    m0 = miso_hi;
    mon = 1'b1;
    cs_n4 = 1'b0;
    frame(1'b0, 48, 520'({8'hFF, 40'hFFFFFFFFFF}), 40, 10, rx);
    cs_n4 = 1'b0;
    repeat (300) @(negedge clk);
    cs_n4 = 1'b1;
    repeat (20) @(negedge clk);
    mon = 1'b0;
    n_assert++;
    if (n_start4 - s0 !== 0) begin
      n_fail++; $display("FAIL ill_starts: got %0d want 0", n_start4 - s0);
    end
    n_assert++;
    if (miso_hi - m0 !== 0) begin
      n_fail++; $display("FAIL ill_miso: got %0d high want 0", miso_hi - m0);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h20) begin
      n_fail++; $display("FAIL ill_status: got %h want 20", st);
    end
  endtask

  task automatic test_busy_write();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    int s0;
    do_reset();
    auto4 = 1'b0;
    s0 = n_start4;
    frame(1'b0, 264, 520'({8'h02, D1, K1}), 20, 200, rx);
    frame(1'b0, 264, 520'({8'h01, D2, K2}), 20, 200, rx);
    n_assert++;
    if (n_start4 - s0 !== 1) begin
      n_fail++; $display("FAIL bw_starts: got %0d want 1", n_start4 - s0);
    end
    n_assert++;
    if (core_data4 !== D1) begin
      n_fail++; $display("FAIL bw_data: got %h want %h", core_data4, D1);
    end
    n_assert++;
    if (core_key4 !== K1) begin
      n_fail++; $display("FAIL bw_key: got %h want %h", core_key4, K1);
    end
    n_assert++;
    if (core_mode4 !== 1'b0) begin
      n_fail++; $display("FAIL bw_mode: got %b want 0", core_mode4);
    end
    n_assert++;
    if (busy4 !== 1'b1) begin
      n_fail++; $display("FAIL bw_busy: got %b want 1", busy4);
    end
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'hA0) begin
      n_fail++; $display("FAIL bw_status: got %h want a0", st);
    end
    n_assert++;
    if (res !== 128'h0) begin
      n_fail++; $display("FAIL bw_result: got %h want 0", res);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    logic [7:0] rd_cmd;
    do_reset();
    auto4 = 1'b0;
    frame(1'b0, 264, 520'({8'h01, D2, K2}), 20, 200, rx);
    rd_cmd = 8'h03;
    cs_n4 = 1'b0;
    #40;
    for (int i = 0; i < 78; i++) begin
      mosi = (i < 8) ? rd_cmd[7-i] : 1'b0;
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
    #20;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (miso4 !== 1'b0) begin
      n_fail++; $display("FAIL mr_miso: got %b want 0", miso4);
    end
    n_assert++;
    if (miso_oe4 !== 1'b0) begin
      n_fail++; $display("FAIL mr_miso_oe: got %b want 0", miso_oe4);
    end
    n_assert++;
    if (busy4 !== 1'b0) begin
      n_fail++; $display("FAIL mr_busy: got %b want 0", busy4);
    end
    cs_n4 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    core_result4 = D2;
    kick4 = 1'b1;
    @(negedge clk);
    kick4 = 1'b0;
    repeat (5) @(negedge clk);
    do_read(1'b0, 200, st, res);
    n_assert++;
    if (st !== 8'h00) begin
      n_fail++; $display("FAIL mr_status: got %h want 00", st);
    end
  endtask

  task automatic test_back_to_back();
    logic [519:0] rx;
    logic [7:0] st;
    logic [127:0] res;
    logic [127:0] exp_res;
    int s0;
    do_reset();
    auto8 = 1'b1;
    s0 = n_start8;
    exp_res = ~D6;
    frame(1'b1, 392, 520'({8'h02, D6, K6}), 20, 10, rx);
    do_read(1'b1, 10, st, res);
    frame(1'b1, 392, 520'({8'h02, D1, K6}), 20, 200, rx);
    n_assert++;
    if (st !== 8'h40) begin
      n_fail++; $display("FAIL b2b_status: got %h want 40", st);
    end
    n_assert++;
    if (res !== exp_res) begin
      n_fail++; $display("FAIL b2b_result: got %h want %h", res, exp_res);
    end
    n_assert++;
    if (n_start8 - s0 !== 2) begin
      n_fail++; $display("FAIL b2b_starts: got %0d want 2", n_start8 - s0);
    end
    n_assert++;
    if (core_data8 !== D1) begin
      n_fail++; $display("FAIL b2b_data: got %h want %h", core_data8, D1);
    end
    n_assert++;
    if (core_key8 !== K6) begin
      n_fail++; $display("FAIL b2b_key: got %h want %h", core_key8, K6);
    end
    n_assert++;
    if (core_mode8 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_mode: got %b want 0", core_mode8);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    auto4 = 1'b1;
    auto8 = 1'b1;
    mon = 1'b0;
    kick4 = 1'b0;
    rst = 1'b1;
    cs_n4 = 1'b1;
    cs_n8 = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_abort();
    test_illegal();
    test_busy_write();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
